if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, in-order imem requests, prefetch FIFO,
// register-field decode and redirect handling with stale-response discard.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst,
    output logic [15:0] pc,
    output logic [2:0]  read1_addr,
    output logic [2:0]  read2_addr,
    output logic [2:0]  write_addr,
    output logic        if_id_en,
    output logic        inst_valid
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [15:0]   fetch_pc;
    logic [15:0]   buf_word [BUF_DEPTH];
    logic [15:0]   buf_addr [BUF_DEPTH];
    logic [15:0]   fl_addr  [BUF_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, fl_rd, fl_wr;
    logic [CW-1:0] count, outstanding, drop;

    logic [SW-1:0] occupancy;
    logic          grant, push, pop;

    // Credit covers words in flight plus words buffered, so a response always has a slot.
    assign occupancy = {1'b0, outstanding} + {1'b0, count};
    assign imem_req  = ~rst & ~redirect & (occupancy < SW'(BUF_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign inst_valid = ~rst & ~redirect & (count != '0);
    assign pop        = inst_valid & ~stall;
    assign push       = ~rst & ~redirect & imem_rvalid & (drop == '0);
    assign if_id_en   = ~stall;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inst = 16'h0000;
        pc   = 16'h0000;
        if (inst_valid) begin
            inst = buf_word[rd_ptr];
            pc   = buf_addr[rd_ptr] + 16'd1;
        end
        read1_addr = inst[11:9];
        read2_addr = inst[8:6];
        write_addr = (inst[15:12] == 4'h0) ? inst[5:3] : inst[8:6];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fl_rd       <= '0;
            fl_wr       <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (grant)       fl_wr <= fl_wr + PW'(1);
            if (imem_rvalid) fl_rd <= fl_rd + PW'(1);

            if (redirect) begin
                // Everything still in flight is now stale, except a response landing right now.
                fetch_pc <= redirect_pc;
                drop     <= outstanding - CW'(imem_rvalid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (grant)                        fetch_pc <= fetch_pc + 16'd1;
                if (imem_rvalid && drop != '0)    drop     <= drop - CW'(1);
                if (push)                         wr_ptr   <= wr_ptr + PW'(1);
                if (pop)                          rd_ptr   <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (grant) fl_addr[fl_wr] <= fetch_pc;
        if (push) begin
            buf_word[wr_ptr] <= imem_rdata;
            buf_addr[wr_ptr] <= fl_addr[fl_rd];
        end
    end

endmodule
